// File: rtl/r22sdf_pkg.sv
// Shared types and constants for the radix-2^2 SDF FFT pipeline, plus the
// twiddle-address rule so that other stages and models compute it identically.
package r22sdf_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_LOG_N = 6;

  typedef logic signed [DEF_WIDTH-1:0] data_t;
  typedef logic        [DEF_LOG_N-1:0] taddr_t;

  localparam data_t Q15_MAX = 16'sh7FFF;
  localparam data_t Q15_MIN = 16'sh8000;

  // Twiddle address for a sample position inside a sub-FFT of 2**log_m points.
  function automatic taddr_t tw_addr(input taddr_t count, input int log_m);
    int sel;
    int num;
    sel = (int'(count[log_m-2]) << 32'sd1) | int'(count[log_m-1]);
    num = (int'(count) & ((32'sd1 << (log_m - 32'sd2)) - 32'sd1)) << (DEF_LOG_N - log_m);
    return taddr_t'(num * sel);
  endfunction

endpackage

// File: rtl/sdf_cmult.sv
// Two-stage complex multiplier: registered partial products, then sum, scale,
// saturate and bypass select. Rounding is enabled by defining SDF_TW_ROUND_EN.
module sdf_cmult
  import r22sdf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_en,
  input  logic                    in_bypass,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  input  logic signed [WIDTH-1:0] tw_re,
  input  logic signed [WIDTH-1:0] tw_im,
  output logic                    out_en,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + 1;
  localparam int QW = SW - (WIDTH - 1);
`ifdef SDF_TW_ROUND_EN
  localparam logic signed [SW-1:0] RND_K = {{(SW-1){1'b0}}, 1'b1} << (WIDTH - 2);
`else
  localparam logic signed [SW-1:0] RND_K = {SW{1'b0}};
`endif

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [QW-1:0] v);
    logic signed [WIDTH-1:0] r;
    if ((v[QW-1:WIDTH-1] == {(QW-WIDTH+1){1'b0}}) || (v[QW-1:WIDTH-1] == {(QW-WIDTH+1){1'b1}})) begin
      r = v[WIDTH-1:0];
    end else if (v[QW-1]) begin
      r = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      r = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return r;
  endfunction

  logic signed [PW-1:0]    p_rr_q, p_rr_d, p_ii_q, p_ii_d, p_ri_q, p_ri_d, p_ir_q, p_ir_d;
  logic signed [WIDTH-1:0] byp_re_q, byp_re_d, byp_im_q, byp_im_d;
  logic                    byp_q, byp_d, v2_q, v2_d;
  logic                    en_q, en_d;
  logic signed [WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic signed [SW-1:0]    sum_re, sum_im;
  logic signed [QW-1:0]    nrw_re, nrw_im;

  // Product capture and output select
  always_comb begin
    sum_re = SW'(p_rr_q) - SW'(p_ii_q) + RND_K;
    sum_im = SW'(p_ri_q) + SW'(p_ir_q) + RND_K;
    nrw_re = QW'(sum_re >>> (WIDTH - 1));
    nrw_im = QW'(sum_im >>> (WIDTH - 1));

    v2_d = in_en;
    if (in_en) begin
      p_rr_d   = PW'(in_re) * PW'(tw_re);
      p_ii_d   = PW'(in_im) * PW'(tw_im);
      p_ri_d   = PW'(in_re) * PW'(tw_im);
      p_ir_d   = PW'(in_im) * PW'(tw_re);
      byp_d    = in_bypass;
      byp_re_d = in_re;
      byp_im_d = in_im;
    end else begin
      p_rr_d   = p_rr_q;
      p_ii_d   = p_ii_q;
      p_ri_d   = p_ri_q;
      p_ir_d   = p_ir_q;
      byp_d    = byp_q;
      byp_re_d = byp_re_q;
      byp_im_d = byp_im_q;
    end

    // Outputs hold their last value through bubbles
    en_d = v2_q;
    if (v2_q) begin
      if (byp_q) begin
        re_d = byp_re_q;
        im_d = byp_im_q;
      end else begin
        re_d = sat(nrw_re);
        im_d = sat(nrw_im);
      end
    end else begin
      re_d = re_q;
      im_d = im_q;
    end
  end

  // Pipeline registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_rr_q   <= {PW{1'b0}};
      p_ii_q   <= {PW{1'b0}};
      p_ri_q   <= {PW{1'b0}};
      p_ir_q   <= {PW{1'b0}};
      byp_q    <= 1'b0;
      byp_re_q <= {WIDTH{1'b0}};
      byp_im_q <= {WIDTH{1'b0}};
      v2_q     <= 1'b0;
      en_q     <= 1'b0;
      re_q     <= {WIDTH{1'b0}};
      im_q     <= {WIDTH{1'b0}};
    end else begin
      p_rr_q   <= p_rr_d;
      p_ii_q   <= p_ii_d;
      p_ri_q   <= p_ri_d;
      p_ir_q   <= p_ir_d;
      byp_q    <= byp_d;
      byp_re_q <= byp_re_d;
      byp_im_q <= byp_im_d;
      v2_q     <= v2_d;
      en_q     <= en_d;
      re_q     <= re_d;
      im_q     <= im_d;
    end
  end

  assign out_en = en_q;
  assign out_re = re_q;
  assign out_im = im_q;

endmodule

// File: rtl/sdf_twiddle_mult.sv
// Twiddle-multiply stage between SDF stage pairs: sample counter, registered table
// address, bypass for address 0, and a 3-cycle valid pipe. Option: SDF_TW_ROUND_EN.
module sdf_twiddle_mult
  import r22sdf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LOG_N = DEF_LOG_N,
  parameter int LOG_M = 6
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    di_en,
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
  output logic        [LOG_N-1:0] taddr,
  input  logic signed [WIDTH-1:0] tdata_r,
  input  logic signed [WIDTH-1:0] tdata_i,
  output logic                    do_en,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im
);

  localparam logic [LOG_M-1:0] CNT_ONE = {{(LOG_M-1){1'b0}}, 1'b1};

  logic [LOG_M-1:0]        di_count_q, di_count_d;
  logic [LOG_N-1:0]        taddr_q, taddr_d, tw_num;
  logic [1:0]              tw_sel;
  logic signed [WIDTH-1:0] d1_re_q, d1_re_d, d1_im_q, d1_im_d;
  logic                    v1_q, v1_d;

  // Counter, address and first data stage advance only on valid input
  always_comb begin
    tw_sel = {di_count_q[LOG_M-2], di_count_q[LOG_M-1]};
    tw_num = LOG_N'(di_count_q[LOG_M-3:0]) << (LOG_N - LOG_M);
    v1_d   = di_en;
    if (di_en) begin
      di_count_d = di_count_q + CNT_ONE;
      taddr_d    = tw_num * {{(LOG_N-2){1'b0}}, tw_sel};
      d1_re_d    = di_re;
      d1_im_d    = di_im;
    end else begin
      di_count_d = di_count_q;
      taddr_d    = taddr_q;
      d1_re_d    = d1_re_q;
      d1_im_d    = d1_im_q;
    end
  end

  // First pipeline stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      di_count_q <= {LOG_M{1'b0}};
      taddr_q    <= {LOG_N{1'b0}};
      d1_re_q    <= {WIDTH{1'b0}};
      d1_im_q    <= {WIDTH{1'b0}};
      v1_q       <= 1'b0;
    end else begin
      di_count_q <= di_count_d;
      taddr_q    <= taddr_d;
      d1_re_q    <= d1_re_d;
      d1_im_q    <= d1_im_d;
      v1_q       <= v1_d;
    end
  end

  assign taddr = taddr_q;

  // Table address 0 holds 0+j0, so it selects the pass-through path
  sdf_cmult #(.WIDTH(WIDTH)) u_cmult (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_en     (v1_q),
    .in_bypass (taddr_q == {LOG_N{1'b0}}),
    .in_re     (d1_re_q),
    .in_im     (d1_im_q),
    .tw_re     (tdata_r),
    .tw_im     (tdata_i),
    .out_en    (do_en),
    .out_re    (do_re),
    .out_im    (do_im)
  );

endmodule

// File: tb/tb_sdf_twiddle_mult.sv
// Self-checking bench for sdf_twiddle_mult (64-point, LOG_M=6): twiddle ROM model,
// hand-computed vectors, and a sample-level reference with a 3-cycle latency queue.
module tb_sdf_twiddle_mult;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        di_en;
  logic [15:0] di_re, di_im;
  logic [5:0]  taddr;
  logic [15:0] tdata_r, tdata_i;
  logic        do_en;
  logic [15:0] do_re, do_im;

  logic [15:0] tw_r_tab [64];
  logic [15:0] tw_i_tab [64];

  int checks = 0;
  int failures = 0;

  int          cnt_m;
  int          taddr_m;
  logic        pv  [3];
  logic [15:0] pre [3];
  logic [15:0] pim [3];
  logic [15:0] last_re, last_im;

  typedef struct {
    int          cnt;
    logic [15:0] ire;
    logic [15:0] iim;
    logic [15:0] ore;
    logic [15:0] oim;
  } vec_t;
  vec_t vt [6];

  always #5 clock = ~clock;

  assign tdata_r = tw_r_tab[taddr];
  assign tdata_i = tw_i_tab[taddr];

  sdf_twiddle_mult #(.WIDTH(16), .LOG_N(6), .LOG_M(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .di_en   (di_en),
    .di_re   (di_re),
    .di_im   (di_im),
    .taddr   (taddr),
    .tdata_r (tdata_r),
    .tdata_i (tdata_i),
    .do_en   (do_en),
    .do_re   (do_re),
    .do_im   (do_im)
  );

  function automatic int q15(real x);
    real s;
    int  v;
    s = x * 32768.0;
    v = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // 64/64 address rule: quarter 0 -> 0, 1 -> 2n, 2 -> n, 3 -> 3n
  function automatic int exp_addr(int c);
    int n;
    n = c % 16;
    case (c / 16)
      0:       return 0;
      1:       return 2 * n;
      2:       return n;
      default: return 3 * n;
    endcase
  endfunction

  function automatic logic [15:0] scale(longint s);
    longint v;
`ifdef SDF_TW_ROUND_EN
    v = (s + 64'sd16384) >>> 15;
`else
    v = s >>> 15;
`endif
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  function automatic bit legal(int a);
    return (a <= 15) || ((a % 2 == 0) && (a <= 30)) || ((a % 3 == 0) && (a <= 45));
  endfunction

  function automatic logic [15:0] rnd_word();
    logic [31:0] r;
    r = $urandom();
    if (r[31:29] == 3'd0) return 16'h8000;
    return r[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    cnt_m   = 0;
    taddr_m = 0;
    last_re = 16'h0000;
    last_im = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      pv[i]  = 1'b0;
      pre[i] = 16'h0000;
      pim[i] = 16'h0000;
    end
  endtask

  // Called at a falling edge: check outputs, update model, drive next input.
  task automatic step(input logic en, input logic [15:0] re, input logic [15:0] im);
    int          a;
    longint      ar, ai, wr, wi;
    logic [15:0] ere, eim;
    chk("do_en", {31'd0, do_en}, {31'd0, pv[2]});
    if (pv[2]) begin
      chk("do_re", {16'd0, do_re}, {16'd0, pre[2]});
      chk("do_im", {16'd0, do_im}, {16'd0, pim[2]});
      last_re = pre[2];
      last_im = pim[2];
    end else begin
      chk("hold_re", {16'd0, do_re}, {16'd0, last_re});
      chk("hold_im", {16'd0, do_im}, {16'd0, last_im});
    end
    chk("taddr", {26'd0, taddr}, 32'(taddr_m));
    chk("taddr_legal", {31'd0, legal(int'(taddr))}, 32'd1);

    pv[2] = pv[1]; pre[2] = pre[1]; pim[2] = pim[1];
    pv[1] = pv[0]; pre[1] = pre[0]; pim[1] = pim[0];
    pv[0] = en;
    ere = 16'h0000;
    eim = 16'h0000;
    if (en) begin
      a = exp_addr(cnt_m);
      taddr_m = a;
      if (a == 0) begin
        ere = re;
        eim = im;
      end else begin
        ar = longint'($signed(re));
        ai = longint'($signed(im));
        wr = longint'($signed(tw_r_tab[a]));
        wi = longint'($signed(tw_i_tab[a]));
        ere = scale(ar * wr - ai * wi);
        eim = scale(ar * wi + ai * wr);
      end
      cnt_m = (cnt_m + 1) % 64;
    end
    pre[0] = ere;
    pim[0] = eim;

    di_en = en;
    di_re = re;
    di_im = im;
    @(negedge clock);
  endtask

  // Asserts reset between edges and checks that it acts without a clock edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    di_en   = 1'b0;
    #1;
    chk("rst_do_en", {31'd0, do_en}, 32'd0);
    chk("rst_do_re", {16'd0, do_re}, 32'd0);
    chk("rst_do_im", {16'd0, do_im}, 32'd0);
    chk("rst_taddr", {26'd0, taddr}, 32'd0);
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    int cyc;
    reset_n = 1'b0;
    di_en   = 1'b0;
    di_re   = 16'h0000;
    di_im   = 16'h0000;
    tw_r_tab[0] = 16'h0000;
    tw_i_tab[0] = 16'h0000;
    for (int k = 1; k < 64; k++) begin
      tw_r_tab[k] = 16'(q15($cos(2.0 * 3.14159265358979 * k / 64.0)));
      tw_i_tab[k] = 16'(q15(-$sin(2.0 * 3.14159265358979 * k / 64.0)));
    end
    vt[0] = '{17, 16'h4000, 16'h0000, 16'h3EC5,
`ifdef SDF_TW_ROUND_EN
              16'hF384};
`else
              16'hF383};
`endif
    vt[1] = '{24, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF};
    vt[2] = '{5,  16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC};
    vt[3] = '{40, 16'h4000, 16'h0000, 16'h2D41, 16'hD2BF};
    vt[4] = '{16, 16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC};
    vt[5] = '{48, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    model_clear();

    @(negedge clock);
    do_reset();

    // Continuous frame of 0.5+j0
    for (int i = 0; i < 64; i++) step(1'b1, 16'h4000, 16'h0000);
    // Reset while samples are in flight
    for (int i = 0; i < 5; i++) step(1'b1, 16'h4000, 16'h0000);
    do_reset();

    // Bypass quarter
    for (int i = 0; i < 16; i++) step(1'b1, 16'h1234, 16'hFEDC);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 16'h0000);

    // Table vectors at chosen counts
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int j = 0; j < vt[v].cnt; j++) step(1'b1, 16'h0000, 16'h0000);
      step(1'b1, vt[v].ire, vt[v].iim);
      step(1'b0, 16'h0000, 16'h0000);
      step(1'b0, 16'h0000, 16'h0000);
      chk($sformatf("vec%0d_en", v), {31'd0, do_en}, 32'd1);
      chk($sformatf("vec%0d_re", v), {16'd0, do_re}, {16'd0, vt[v].ore});
      chk($sformatf("vec%0d_im", v), {16'd0, do_im}, {16'd0, vt[v].oim});
    end

    // Gapped frame, valid every other clock
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 16'h4000, 16'h0000);
      step(1'b0, 16'h0000, 16'h0000);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 16'h0000);

    // Reset at sample 40, then four random gapped frames
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, rnd_word(), rnd_word());
    do_reset();
    n = 0;
    cyc = 0;
    while ((n < 256) && (cyc < 4000)) begin
      if ($urandom_range(0, 3) != 0) begin
        step(1'b1, rnd_word(), rnd_word());
        n++;
      end else begin
        step(1'b0, rnd_word(), rnd_word());
      end
      cyc++;
    end
    chk("random_sample_budget", 32'(n), 32'd256);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
